int_res_mem_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer for the intermediate-result CIM memory. The memory has 4 banks of 14336 words, 9 bits per word.
- Shares that memory between NUM_REQ requesters: the master controller, MAC, LayerNorm and Softmax units.
- Splits DOUBLE_WIDTH (18-bit) accesses into two consecutive single-word memory accesses.
- Reassembles read data and routes responses back to the originating requester.
- Bank decode sits downstream in the memory wrapper; this block presents a flat word address.

---
 rtl/int_res_mem_arbiter_pkg.sv | 28 ++
 rtl/int_res_mem_arbiter_rr_arbiter.sv | 41 ++++
 rtl/int_res_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_int_res_mem_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/int_res_mem_arbiter_pkg.sv
// Shared types and constants for the intermediate-result CIM memory arbiter.
// Holds word/address types, width selector, FSM states and response-tracking kinds.
package int_res_mem_arbiter_pkg;

    localparam int CIM_INT_RES_NUM_BANKS          = 4;
    localparam int CIM_INT_RES_BANK_SIZE_NUM_WORD = 14336;
    localparam int INT_RES_MEM_NUM_WORD           = CIM_INT_RES_NUM_BANKS * CIM_INT_RES_BANK_SIZE_NUM_WORD;

    typedef logic [15:0] IntResAddr_t;
    typedef logic [8:0]  IntResSingle_t;
    typedef logic [17:0] IntResDouble_t;

    typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} DataWidth_t;
    typedef enum logic {ARB = 1'b0, SECOND = 1'b1} ArbState_t;

    // Kind of read issued in the previous cycle; DLOW only captures the low word.
    typedef enum logic [1:0] {
        RSP_SINGLE = 2'd0,
        RSP_DLOW   = 2'd1,
        RSP_DHIGH  = 2'd2,
        RSP_OOB    = 2'd3
    } RspKind_t;

    function automatic IntResDouble_t sext_single(input IntResSingle_t w);
        return {{9{w[8]}}, w};
    endfunction

endpackage

// File: rtl/int_res_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid index at or after the pointer,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    localparam logic [PW:0] NW = (PW+1)'(N);

    logic [PW:0] w_cand;

    // Scan N candidates starting at the pointer and keep the first valid one.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_cand >= NW) begin
                w_cand = w_cand - NW;
            end else begin
                w_cand = w_cand;
            end
            if (!o_any && i_valid[w_cand[PW-1:0]]) begin
                o_any                     = 1'b1;
                o_idx                     = w_cand[PW-1:0];
                o_grant[w_cand[PW-1:0]]   = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the intermediate-result memory:
// splits double-width accesses into two words and routes read data back.
module int_res_mem_arbiter
    import int_res_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_LIMIT = INT_RES_MEM_NUM_WORD
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ-1:0]           i_req_wr,
    input  DataWidth_t [NUM_REQ-1:0]     i_req_width,
    input  IntResAddr_t [NUM_REQ-1:0]    i_req_addr,
    input  IntResDouble_t [NUM_REQ-1:0]  i_req_wdata,
    output logic [NUM_REQ-1:0]           o_req_grant,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    output IntResDouble_t                o_rsp_rdata,
    output logic                         o_mem_en,
    output logic                         o_mem_wr,
    output IntResAddr_t                  o_mem_addr,
    output IntResSingle_t                o_mem_wdata,
    input  IntResSingle_t                i_mem_rdata,
    output logic                         o_busy,
    output logic                         o_err_oob
);

    localparam int          IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [16:0] LIMIT = 17'(ADDR_LIMIT);

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;

    ArbState_t     r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    IntResAddr_t   r_sec_addr;
    IntResSingle_t r_sec_wdata;
    logic          r_sec_wr;
    logic [IW-1:0] r_sec_id;
    logic          w_latch;

    logic          r_p1_valid, w_p1_valid_nxt;
    RspKind_t      r_p1_kind, w_p1_kind_nxt;
    logic [IW-1:0] r_p1_id, w_p1_id_nxt;
    IntResSingle_t r_low;

    logic          w_sel_wr, w_sel_dbl, w_oob;
    IntResAddr_t   w_sel_addr;
    IntResDouble_t w_sel_wdata;
    logic [16:0]   w_last_addr;

    rr_arbiter #(.N(NUM_REQ), .PW(IW)) u_rr (
        .i_valid (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_wr    = i_req_wr[w_idx];
    assign w_sel_dbl   = (i_req_width[w_idx] == DOUBLE_WIDTH);
    assign w_sel_addr  = i_req_addr[w_idx];
    assign w_sel_wdata = i_req_wdata[w_idx];
    // The last word touched must be below the limit; 17 bits so addr+1 cannot wrap.
    assign w_last_addr = {1'b0, w_sel_addr} + (w_sel_dbl ? 17'd1 : 17'd0);
    assign w_oob       = (w_last_addr >= LIMIT);
    assign o_busy      = (r_state == SECOND) || r_p1_valid;

    // Next-state, pointer, response tracking and memory strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_latch        = 1'b0;
        w_p1_valid_nxt = 1'b0;
        w_p1_kind_nxt  = RSP_SINGLE;
        w_p1_id_nxt    = r_p1_id;
        o_req_grant    = '0;
        o_mem_en       = 1'b0;
        o_mem_wr       = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_err_oob      = 1'b0;
        case (r_state)
            ARB: begin
                // Gated by reset so grants stay low while the block is held in reset.
                if (w_any && !i_rst) begin
                    o_req_grant = w_grant;
                    w_ptr_nxt   = (w_idx == IW'(NUM_REQ-1)) ? '0 : w_idx + IW'(1);
                    w_p1_id_nxt = w_idx;
                    if (w_oob) begin
                        o_err_oob      = 1'b1;
                        w_p1_valid_nxt = !w_sel_wr;
                        w_p1_kind_nxt  = RSP_OOB;
                    end else begin
                        o_mem_en       = 1'b1;
                        o_mem_wr       = w_sel_wr;
                        o_mem_addr     = w_sel_addr;
                        o_mem_wdata    = w_sel_wdata[8:0];
                        w_p1_valid_nxt = !w_sel_wr;
                        w_p1_kind_nxt  = w_sel_dbl ? RSP_DLOW : RSP_SINGLE;
                        w_latch        = w_sel_dbl;
                        w_state_nxt    = w_sel_dbl ? SECOND : ARB;
                    end
                end else begin
                    w_state_nxt = ARB;
                end
            end
            SECOND: begin
                o_mem_en       = 1'b1;
                o_mem_wr       = r_sec_wr;
                o_mem_addr     = r_sec_addr;
                o_mem_wdata    = r_sec_wdata;
                w_p1_valid_nxt = !r_sec_wr;
                w_p1_kind_nxt  = RSP_DHIGH;
                w_p1_id_nxt    = r_sec_id;
                w_state_nxt    = ARB;
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // FSM state and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ARB;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Second-word context captured when a double access is granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sec_addr  <= '0;
            r_sec_wdata <= '0;
            r_sec_wr    <= 1'b0;
            r_sec_id    <= '0;
        end else if (w_latch) begin
            r_sec_addr  <= w_sel_addr + 16'd1;
            r_sec_wdata <= w_sel_wdata[17:9];
            r_sec_wr    <= w_sel_wr;
            r_sec_id    <= w_idx;
        end else begin
            r_sec_addr  <= r_sec_addr;
        end
    end

    // One-deep read tracking; the memory answers exactly one cycle after issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p1_valid <= 1'b0;
            r_p1_kind  <= RSP_SINGLE;
            r_p1_id    <= '0;
            r_low      <= '0;
        end else begin
            r_p1_valid <= w_p1_valid_nxt;
            r_p1_kind  <= w_p1_kind_nxt;
            r_p1_id    <= w_p1_id_nxt;
            r_low      <= (r_p1_valid && (r_p1_kind == RSP_DLOW)) ? i_mem_rdata : r_low;
        end
    end

    // Response routing and read-data assembly.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_rdata = '0;
        if (r_p1_valid) begin
            case (r_p1_kind)
                RSP_SINGLE: begin
                    o_rsp_valid[r_p1_id] = 1'b1;
                    o_rsp_rdata          = sext_single(i_mem_rdata);
                end
                RSP_DHIGH: begin
                    o_rsp_valid[r_p1_id] = 1'b1;
                    o_rsp_rdata          = {i_mem_rdata, r_low};
                end
                RSP_OOB: begin
                    o_rsp_valid[r_p1_id] = 1'b1;
                end
                default: begin
                    o_rsp_rdata = '0;
                end
            endcase
        end else begin
            o_rsp_rdata = '0;
        end
    end

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Directed table-driven bench for int_res_mem_arbiter with a 1-cycle-latency memory model.
module tb_int_res_mem_arbiter;
    import int_res_mem_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            req_valid, req_wr;
    DataWidth_t [3:0]      req_width;
    IntResAddr_t [3:0]     req_addr;
    IntResDouble_t [3:0]   req_wdata;
    logic [3:0]            req_grant, rsp_valid;
    IntResDouble_t         rsp_rdata;
    logic                  mem_en, mem_wr, busy, err_oob;
    IntResAddr_t           mem_addr;
    IntResSingle_t         mem_wdata, mem_rdata;

    logic [8:0] mem [0:65535];
    int n_checks = 0;
    int n_fail   = 0;
    int cur      = -1;

    typedef struct {
        logic [3:0] va, wr, db; logic [15:0] ad; logic [17:0] wd;
        logic [3:0] eg; logic een, ewr; logic [15:0] ea; logic [8:0] ewd;
        logic [3:0] er; logic [17:0] erd; logic eb, eo;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    int_res_mem_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_wr(req_wr),
        .i_req_width(req_width), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_grant(req_grant), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy), .o_err_oob(err_oob)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    function automatic vec_t mk(input logic [3:0] va, input logic [3:0] wr, input logic [3:0] db,
                                input logic [15:0] ad, input logic [17:0] wd, input logic [3:0] eg,
                                input logic een, input logic ewr, input logic [15:0] ea, input logic [8:0] ewd,
                                input logic [3:0] er, input logic [17:0] erd, input logic eb, input logic eo);
        vec_t v;
        v.va = va; v.wr = wr; v.db = db; v.ad = ad; v.wd = wd; v.eg = eg; v.een = een; v.ewr = ewr;
        v.ea = ea; v.ewd = ewd; v.er = er; v.erd = erd; v.eb = eb; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, cur, act, exp);
        end
    endtask

    // Requester i sees address base + 256*i so a wrong index mux shows up on mem_addr.
    task automatic drive(input logic [3:0] va, input logic [3:0] wr, input logic [3:0] db,
                         input logic [15:0] ad, input logic [17:0] wd);
        req_valid = va;
        req_wr    = wr;
        for (int i = 0; i < 4; i++) begin
            req_width[i] = db[i] ? DOUBLE_WIDTH : SINGLE_WIDTH;
            req_addr[i]  = ad + 16'(i * 256);
            req_wdata[i] = wd;
        end
    endtask

    task automatic chk_outs(input logic [3:0] eg, input logic een, input logic ewr, input logic [15:0] ea,
                            input logic [8:0] ewd, input logic [3:0] er, input logic [17:0] erd,
                            input logic eb, input logic eo);
        chk("grant",     32'(req_grant), 32'(eg));
        chk("mem_en",    32'(mem_en),    32'(een));
        chk("mem_wr",    32'(mem_wr),    32'(ewr));
        chk("mem_addr",  32'(mem_addr),  32'(ea));
        chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
        chk("rsp_valid", 32'(rsp_valid), 32'(er));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(erd));
        chk("busy",      32'(busy),      32'(eb));
        chk("err_oob",   32'(err_oob),   32'(eo));
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 9'h000;
        mem[16'h0010] = 9'h011; mem[16'h0110] = 9'h122; mem[16'h0210] = 9'h0F3; mem[16'h0310] = 9'h144;
        mem[16'h1100] = 9'h0AA; mem[16'h1101] = 9'h155; mem[16'h1300] = 9'h1F0; mem[16'hDFFF] = 9'h07F;
        mem_rdata = 9'h000;

        // single write/read, req0 @100
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b0001,4'b0001,4'b0000,16'd100,18'h001A5,4'b0001,1'b1,1'b1,16'd100,9'h1A5, 4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b0001,4'b0000,4'b0000,16'd100,18'h001A5,4'b0001,1'b1,1'b0,16'd100,9'h1A5, 4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b0001,18'h3FFA5,1'b1,1'b0));
        // double write/read, req2 @5000
        vt.push_back(mk(4'b0100,4'b0100,4'b0100,16'd4488,18'h2ABCD,4'b0100,1'b1,1'b1,16'd5000,9'h1CD,4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b1,1'b1,16'd5001,9'h155,4'b0000,18'h0,1'b1,1'b0));
        vt.push_back(mk(4'b0100,4'b0000,4'b0100,16'd4488,18'h0,   4'b0100,1'b1,1'b0,16'd5000,9'h0,  4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b0010,4'b0000,4'b0000,16'hFF64,18'h0,   4'b0000,1'b1,1'b0,16'd5001,9'h0,  4'b0000,18'h0,1'b1,1'b0));
        vt.push_back(mk(4'b0010,4'b0000,4'b0000,16'hFF64,18'h0,   4'b0010,1'b1,1'b0,16'd100,9'h0,   4'b0100,18'h2ABCD,1'b1,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b0010,18'h3FFA5,1'b1,1'b0));
        // round robin, all four continuously valid (pointer starts at 2)
        vt.push_back(mk(4'b1111,4'b0000,4'b0000,16'h0010,18'h0,   4'b0100,1'b1,1'b0,16'h0210,9'h0,  4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b1111,4'b0000,4'b0000,16'h0010,18'h0,   4'b1000,1'b1,1'b0,16'h0310,9'h0,  4'b0100,18'h000F3,1'b1,1'b0));
        vt.push_back(mk(4'b1111,4'b0000,4'b0000,16'h0010,18'h0,   4'b0001,1'b1,1'b0,16'h0010,9'h0,  4'b1000,18'h3FF44,1'b1,1'b0));
        vt.push_back(mk(4'b1111,4'b0000,4'b0000,16'h0010,18'h0,   4'b0010,1'b1,1'b0,16'h0110,9'h0,  4'b0001,18'h00011,1'b1,1'b0));
        vt.push_back(mk(4'b1111,4'b0000,4'b0000,16'h0010,18'h0,   4'b0100,1'b1,1'b0,16'h0210,9'h0,  4'b0010,18'h3FF22,1'b1,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b0100,18'h000F3,1'b1,1'b0));
        // mixed widths: req1 double + req3 single
        vt.push_back(mk(4'b0001,4'b0000,4'b0000,16'h0010,18'h0,   4'b0001,1'b1,1'b0,16'h0010,9'h0,  4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b1010,4'b0000,4'b0010,16'h1000,18'h0,   4'b0010,1'b1,1'b0,16'h1100,9'h0,  4'b0001,18'h00011,1'b1,1'b0));
        vt.push_back(mk(4'b1000,4'b0000,4'b0000,16'h1000,18'h0,   4'b0000,1'b1,1'b0,16'h1101,9'h0,  4'b0000,18'h0,1'b1,1'b0));
        vt.push_back(mk(4'b1000,4'b0000,4'b0000,16'h1000,18'h0,   4'b1000,1'b1,1'b0,16'h1300,9'h0,  4'b0010,18'h2AAAA,1'b1,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b1000,18'h3FFF0,1'b1,1'b0));
        // out of range: single @57344, double @57343, then legal accesses
        vt.push_back(mk(4'b0001,4'b0000,4'b0000,16'hE000,18'h0,   4'b0001,1'b0,1'b0,16'd0,9'h0,     4'b0000,18'h0,1'b0,1'b1));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b0001,18'h0,1'b1,1'b0));
        vt.push_back(mk(4'b0100,4'b0000,4'b0100,16'hDDFF,18'h0,   4'b0100,1'b0,1'b0,16'd0,9'h0,     4'b0000,18'h0,1'b0,1'b1));
        vt.push_back(mk(4'b1000,4'b0000,4'b0000,16'h1000,18'h0,   4'b1000,1'b1,1'b0,16'h1300,9'h0,  4'b0100,18'h0,1'b1,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b1000,18'h3FFF0,1'b1,1'b0));
        vt.push_back(mk(4'b0001,4'b0000,4'b0000,16'hDFFF,18'h0,   4'b0001,1'b1,1'b0,16'hDFFF,9'h0,  4'b0000,18'h0,1'b0,1'b0));
        vt.push_back(mk(4'b0000,4'b0000,4'b0000,16'd0,18'h0,      4'b0000,1'b0,1'b0,16'd0,9'h0,     4'b0001,18'h0007F,1'b1,1'b0));

        // Reset state with every requester asking.
        rst = 1'b1;
        drive(4'b1111, 4'b0000, 4'b1111, 16'd0, 18'h3FFFF);
        #3;
        chk_outs(4'b0000, 1'b0, 1'b0, 16'd0, 9'h0, 4'b0000, 18'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vt.size(); k++) begin
            cur = k;
            drive(vt[k].va, vt[k].wr, vt[k].db, vt[k].ad, vt[k].wd);
            #2;
            chk_outs(vt[k].eg, vt[k].een, vt[k].ewr, vt[k].ea, vt[k].ewd, vt[k].er, vt[k].erd, vt[k].eb, vt[k].eo);
            @(negedge clk);
        end

        // Reset during the second word of a double read by req1.
        cur = 100;
        drive(4'b0010, 4'b0000, 4'b0010, 16'h1000, 18'h0);
        #2;
        chk("rst_seq_grant", 32'(req_grant), 32'h2);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 4'b0000, 16'd0, 18'h0);
        #2;
        chk("rst_seq_second_addr", 32'(mem_addr), 32'h1101);
        chk("rst_seq_second_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        drive(4'b1111, 4'b0000, 4'b0000, 16'h0010, 18'h0);
        #1;
        cur = 101;
        chk_outs(4'b0000, 1'b0, 1'b0, 16'd0, 9'h0, 4'b0000, 18'h0, 1'b0, 1'b0);
        @(negedge clk);
        cur = 102;
        chk("rst_hold_rsp", 32'(rsp_valid), 32'h0);
        chk("rst_hold_grant", 32'(req_grant), 32'h0);
        rst = 1'b0;
        #2;
        cur = 103;
        chk_outs(4'b0001, 1'b1, 1'b0, 16'h0010, 9'h0, 4'b0000, 18'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 4'b0000, 16'd0, 18'h0);
        #2;
        cur = 104;
        chk_outs(4'b0000, 1'b0, 1'b0, 16'd0, 9'h0, 4'b0001, 18'h00011, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        cur = 105;
        chk("post_rst_idle_rsp", 32'(rsp_valid), 32'h0);
        chk("post_rst_idle_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
